// File: rtl/spi_request_scheduler_pkg.sv
// Shared types for the SPI request scheduler: FSM state encoding, grant ids
// and the round-robin arbitration helper.
package spi_request_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_THERM_WAIT = 2'd1,
    ST_PROG_WAIT  = 2'd2,
    ST_RELEASE    = 2'd3
  } sched_state_t;

  localparam logic GRANT_THERM = 1'b0;
  localparam logic GRANT_PROG  = 1'b1;

  // With both requesters pending, the one not served last time wins.
  function automatic logic pick_grant(input logic poll_pend,
                                      input logic prog_pend,
                                      input logic last_grant);
    logic grant;
    if (poll_pend && prog_pend) grant = ~last_grant;
    else if (poll_pend)         grant = GRANT_THERM;
    else                        grant = GRANT_PROG;
    return grant;
  endfunction

endpackage

// File: rtl/spi_request_scheduler_tick.sv
// Free-running 0..g_max-1 counter; o_tick is high during the wrap cycle.
// Held at zero while i_en is low.
module tick_counter #(
  parameter int g_max = 10
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (g_max > 1) ? $clog2(g_max) : 1;
  localparam logic [CW-1:0] LAST = CW'(g_max - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)         count <= '0;
    else if (!i_en)         count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  assign o_tick = i_en && (count == LAST);

endmodule

// File: rtl/spi_request_scheduler.sv
// Arbitrates periodic thermometer polls and on-demand program loads onto the
// SPI handler's level request/ready handshake, one transaction at a time.
module spi_request_scheduler
  import spi_request_scheduler_pkg::*;
#(
  parameter int g_poll_ticks = 10,
  parameter int g_timeout    = 400,
  parameter int g_temp_width = 10
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic                    i_prog_req,
  input  logic                    i_clr_err,
  output logic                    o_read_therm,
  input  logic                    i_therm_ready,
  input  logic [g_temp_width-1:0] i_spi_temperature,
  output logic                    o_read_program,
  input  logic                    i_program_ready,
  output logic [g_temp_width-1:0] o_temperature,
  output logic                    o_temp_valid,
  output logic                    o_temp_update,
  output logic                    o_prog_busy,
  output logic                    o_prog_done,
  output logic                    o_timeout_err
);

  localparam int TW = (g_timeout > 1) ? $clog2(g_timeout) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(g_timeout - 1);

  sched_state_t state, state_nxt;
  logic          poll_tick;
  logic          poll_pend, poll_pend_nxt;
  logic          prog_pend, prog_pend_nxt;
  logic          last_grant, last_grant_nxt;
  logic          grant;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          read_therm_nxt, read_prog_nxt;
  logic [g_temp_width-1:0] temp_nxt;
  logic          valid_nxt, update_nxt, done_nxt, err_nxt;
  logic          release_ready;

  tick_counter #(.g_max(g_poll_ticks)) u_poll_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (i_enable),
    .o_tick    (poll_tick)
  );

  assign o_prog_busy   = prog_pend | (state == ST_PROG_WAIT);
  assign release_ready = (last_grant == GRANT_PROG) ? i_program_ready : i_therm_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= ST_IDLE;
      poll_pend      <= 1'b0;
      prog_pend      <= 1'b0;
      last_grant     <= GRANT_PROG;
      tmo            <= '0;
      o_read_therm   <= 1'b0;
      o_read_program <= 1'b0;
      o_temperature  <= '0;
      o_temp_valid   <= 1'b0;
      o_temp_update  <= 1'b0;
      o_prog_done    <= 1'b0;
      o_timeout_err  <= 1'b0;
    end else begin
      state          <= state_nxt;
      poll_pend      <= poll_pend_nxt;
      prog_pend      <= prog_pend_nxt;
      last_grant     <= last_grant_nxt;
      tmo            <= tmo_nxt;
      o_read_therm   <= read_therm_nxt;
      o_read_program <= read_prog_nxt;
      o_temperature  <= temp_nxt;
      o_temp_valid   <= valid_nxt;
      o_temp_update  <= update_nxt;
      o_prog_done    <= done_nxt;
      o_timeout_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    poll_pend_nxt  = poll_pend;
    prog_pend_nxt  = prog_pend;
    last_grant_nxt = last_grant;
    tmo_nxt        = tmo;
    read_therm_nxt = 1'b0;
    read_prog_nxt  = 1'b0;
    temp_nxt       = o_temperature;
    valid_nxt      = o_temp_valid;
    update_nxt     = 1'b0;
    done_nxt       = 1'b0;
    err_nxt        = o_timeout_err & ~i_clr_err;
    grant          = pick_grant(poll_pend, prog_pend, last_grant);

    case (state)
      ST_IDLE: begin
        if (poll_pend || prog_pend) begin
          last_grant_nxt = grant;
          tmo_nxt        = '0;
          if (grant == GRANT_THERM) begin
            poll_pend_nxt  = 1'b0;
            read_therm_nxt = 1'b1;
            state_nxt      = ST_THERM_WAIT;
          end else begin
            prog_pend_nxt  = 1'b0;
            read_prog_nxt  = 1'b1;
            state_nxt      = ST_PROG_WAIT;
          end
        end
      end
      // A ready arriving on the last allowed cycle still counts as success.
      ST_THERM_WAIT: begin
        if (i_therm_ready) begin
          temp_nxt   = i_spi_temperature;
          valid_nxt  = 1'b1;
          update_nxt = 1'b1;
          state_nxt  = ST_RELEASE;
        end else if (tmo == TMO_LAST) begin
          err_nxt   = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = ST_RELEASE;
        end else begin
          tmo_nxt        = tmo + 1'b1;
          read_therm_nxt = 1'b1;
        end
      end
      ST_PROG_WAIT: begin
        if (i_program_ready) begin
          done_nxt  = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (tmo == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = ST_RELEASE;
        end else begin
          tmo_nxt       = tmo + 1'b1;
          read_prog_nxt = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!release_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Poll wraps while busy collapse into a single pending read.
    if (poll_tick) poll_pend_nxt = 1'b1;
    if (!i_enable) poll_pend_nxt = 1'b0;
    if (i_prog_req && !o_prog_busy) prog_pend_nxt = 1'b1;
  end

endmodule
